// File: rtl/snake_cmd_pkg.sv
// Shared types and byte constants for the snake controller command decoder.
// Optional build macro SNAKE_NOREV_EN (used by snake_cmd_decoder) enables the
// reversal filter; the helper is_opposite() below supports it.
package snake_cmd_pkg;

    // Committed / pending snake direction, encoding fixed by the dir_out port.
    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    // Packet parser position: which bytes of "! B btn state chk" have been seen.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GOT_BANG  = 3'd1,
        ST_GOT_B     = 3'd2,
        ST_GOT_BTN   = 3'd3,
        ST_GOT_STATE = 3'd4
    } pstate_t;

    // Packet framing bytes.
    localparam logic [7:0] BYTE_BANG   = 8'h21;
    localparam logic [7:0] BYTE_B      = 8'h42;

    // Button codes ('1'..'8').
    localparam logic [7:0] BTN_1       = 8'h31;
    localparam logic [7:0] BTN_5       = 8'h35;
    localparam logic [7:0] BTN_6       = 8'h36;
    localparam logic [7:0] BTN_7       = 8'h37;
    localparam logic [7:0] BTN_8       = 8'h38;

    // Button state codes ('0' released, '1' pressed).
    localparam logic [7:0] STATE_REL   = 8'h30;
    localparam logic [7:0] STATE_PRESS = 8'h31;

    // A packet is good when its five bytes sum (mod 256) to this value.
    localparam logic [7:0] CHK_GOOD    = 8'hFF;

    // Direction buttons are '5'..'8'; anything else maps to RIGHT but callers
    // only use the result after checking the button is a direction button.
    function automatic dir_t btn_to_dir(input logic [7:0] btn);
        dir_t d;
        case (btn)
            BTN_5:   d = UP;
            BTN_6:   d = DOWN;
            BTN_7:   d = LEFT;
            default: d = RIGHT;
        endcase
        return d;
    endfunction

    // True when a and b point in opposite directions (snake would reverse).
    function automatic logic is_opposite(input dir_t a, input dir_t b);
        logic r;
        case (a)
            UP:      r = (b == DOWN);
            DOWN:    r = (b == UP);
            LEFT:    r = (b == RIGHT);
            default: r = (b == LEFT);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bf_pkt_parser.sv
// Byte-stream parser for 5-byte controller packets "! B btn state chk".
// Tracks framing, accumulates the checksum and abandons a partial packet when
// the inter-byte gap reaches TIMEOUT_CYCLES. Results are strobed combinationally
// in the cycle the checksum byte arrives so the top can register them at once.
module bf_pkt_parser
    import snake_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       cmd_vld_o,
    output logic [7:0] cmd_btn_o,
    output logic [7:0] cmd_state_o,
    output logic       chk_err_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    pstate_t       state_q, state_d;
    logic [7:0]    btn_q, btn_d;
    logic [7:0]    st_q, st_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    sum_with_rx;
    logic          pkt_done;
    logic          rx_is_bang;

    assign sum_with_rx = sum_q + rx_data_i;
    assign rx_is_bang  = (rx_data_i == BYTE_BANG);

    // Next-state logic: framing, byte latching, checksum and inter-byte timeout.
    always_comb begin
        state_d  = state_q;
        btn_d    = btn_q;
        st_d     = st_q;
        sum_d    = sum_q;
        tmo_d    = tmo_q;
        pkt_done = 1'b0;
        if (rx_valid_i) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_is_bang) begin
                        state_d = ST_GOT_BANG;
                        sum_d   = rx_data_i;
                    end
                end
                ST_GOT_BANG: begin
                    if (rx_data_i == BYTE_B) begin
                        state_d = ST_GOT_B;
                        sum_d   = sum_with_rx;
                    end else begin
                        // An unexpected '!' may be the start of a fresh packet.
                        state_d = rx_is_bang ? ST_GOT_BANG : ST_IDLE;
                        sum_d   = rx_data_i;
                    end
                end
                ST_GOT_B: begin
                    if ((rx_data_i >= BTN_1) && (rx_data_i <= BTN_8)) begin
                        state_d = ST_GOT_BTN;
                        btn_d   = rx_data_i;
                        sum_d   = sum_with_rx;
                    end else begin
                        state_d = rx_is_bang ? ST_GOT_BANG : ST_IDLE;
                        sum_d   = rx_data_i;
                    end
                end
                ST_GOT_BTN: begin
                    if ((rx_data_i == STATE_REL) || (rx_data_i == STATE_PRESS)) begin
                        state_d = ST_GOT_STATE;
                        st_d    = rx_data_i;
                        sum_d   = sum_with_rx;
                    end else begin
                        state_d = rx_is_bang ? ST_GOT_BANG : ST_IDLE;
                        sum_d   = rx_data_i;
                    end
                end
                ST_GOT_STATE: begin
                    // Any byte here is the checksum; the packet ends either way.
                    state_d  = ST_IDLE;
                    pkt_done = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Parser state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            btn_q   <= '0;
            st_q    <= '0;
            sum_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_d;
            st_q    <= st_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
        end
    end

    assign cmd_vld_o   = pkt_done && (sum_with_rx == CHK_GOOD);
    assign chk_err_o   = pkt_done && (sum_with_rx != CHK_GOOD);
    assign cmd_btn_o   = btn_q;
    assign cmd_state_o = st_q;

endmodule

// File: rtl/snake_cmd_decoder.sv
// Snake game command decoder: turns controller packets from a UART byte stream
// into a pending direction (committed on each game tick), pause pulses and a
// saturating checksum-error count.
// Build macro SNAKE_NOREV_EN: when defined, directions equal or opposite to the
// committed direction are dropped instead of becoming pending.
module snake_cmd_decoder
    import snake_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tick,
    output logic [1:0] dir_out,
    output logic       dir_valid,
    output logic       pause_pulse,
    output logic [7:0] err_cnt
);

    logic       cmd_vld;
    logic [7:0] cmd_btn;
    logic [7:0] cmd_state;
    logic       chk_err;

    bf_pkt_parser #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_parser (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .cmd_vld_o   (cmd_vld),
        .cmd_btn_o   (cmd_btn),
        .cmd_state_o (cmd_state),
        .chk_err_o   (chk_err)
    );

    dir_t       dir_q, dir_d;
    dir_t       pend_q, pend_d;
    logic       pend_vld_q, pend_vld_d;
    logic       dir_valid_q;
    logic       pause_q, pause_d;
    logic [7:0] err_q, err_d;

    logic       is_press;
    logic       is_dir_btn;
    dir_t       new_dir;
    logic       dir_ok;
    logic       load;

    assign is_press   = (cmd_state == STATE_PRESS);
    assign is_dir_btn = (cmd_btn >= BTN_5) && (cmd_btn <= BTN_8);
    assign new_dir    = btn_to_dir(cmd_btn);
    assign load       = tick && pend_vld_q;

`ifdef SNAKE_NOREV_EN
    // Compare against the direction committed before this edge.
    assign dir_ok = (new_dir != dir_q) && !is_opposite(new_dir, dir_q);
`else
    assign dir_ok = 1'b1;
`endif

    // Tick commits the old pending value first; a command completing in the
    // same cycle then becomes the new pending value.
    always_comb begin
        dir_d      = dir_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (load) begin
            dir_d      = pend_q;
            pend_vld_d = 1'b0;
        end
        if (cmd_vld && is_press && is_dir_btn && dir_ok) begin
            pend_d     = new_dir;
            pend_vld_d = 1'b1;
        end
    end

    // Pause request and saturating checksum-error count.
    always_comb begin
        pause_d = cmd_vld && is_press && (cmd_btn == BTN_1);
        err_d   = err_q;
        if (chk_err && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Output and pending registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q       <= RIGHT;
            pend_q      <= RIGHT;
            pend_vld_q  <= 1'b0;
            dir_valid_q <= 1'b0;
            pause_q     <= 1'b0;
            err_q       <= '0;
        end else begin
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            dir_valid_q <= load;
            pause_q     <= pause_d;
            err_q       <= err_d;
        end
    end

    assign dir_out     = dir_q;
    assign dir_valid   = dir_valid_q;
    assign pause_pulse = pause_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_snake_cmd_decoder.sv
// Randomized and directed bench for snake_cmd_decoder against a packet-level
// reference model (byte list per packet, idle-gap count, pending/committed dir).
module tb_snake_cmd_decoder;

    localparam int T = 40;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tick;
    logic [1:0] dir_out;
    logic       dir_valid;
    logic       pause_pulse;
    logic [7:0] err_cnt;

    int n_total = 0;
    int n_bad   = 0;

    snake_cmd_decoder #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tick        (tick),
        .dir_out     (dir_out),
        .dir_valid   (dir_valid),
        .pause_pulse (pause_pulse),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] m_part[$];
    int         m_idle;
    logic [1:0] m_dir;
    logic [1:0] m_pend;
    bit         m_pv;
    logic [7:0] m_err;
    bit         m_pause;
    bit         m_dv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] opp(input logic [1:0] d);
        logic [1:0] r;
        case (d)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd0;
            2'd2:    r = 2'd3;
            default: r = 2'd2;
        endcase
        return r;
    endfunction

    function automatic bit byte_fits(input int pos, input logic [7:0] b);
        case (pos)
            0:       return b == 8'h21;
            1:       return b == 8'h42;
            2:       return (b >= 8'h31) && (b <= 8'h38);
            3:       return (b == 8'h30) || (b == 8'h31);
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_part.delete();
        m_idle  = 0;
        m_dir   = 2'd3;
        m_pend  = 2'd3;
        m_pv    = 0;
        m_err   = 8'h00;
        m_pause = 0;
        m_dv    = 0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] b, input bit tk);
        logic [1:0] dir_old;
        logic [7:0] sum;
        logic [1:0] nd;
        bit         ok;
        dir_old = m_dir;
        m_pause = 0;
        m_dv    = tk && m_pv;
        if (tk && m_pv) begin
            m_dir = m_pend;
            m_pv  = 0;
        end
        if (!v) begin
            m_idle++;
            return;
        end
        if (m_part.size() != 0 && m_idle >= T) m_part.delete();
        m_idle = 0;
        if (byte_fits(m_part.size(), b)) begin
            m_part.push_back(b);
        end else if (m_part.size() != 0) begin
            m_part.delete();
            if (b == 8'h21) m_part.push_back(b);
        end
        if (m_part.size() == 5) begin
            sum = 8'h00;
            foreach (m_part[i]) sum = sum + m_part[i];
            if (sum == 8'hFF) begin
                if (m_part[3] == 8'h31 && m_part[2] >= 8'h35) begin
                    nd = 2'(m_part[2] - 8'h35);
`ifdef SNAKE_NOREV_EN
                    ok = (nd != dir_old) && (nd != opp(dir_old));
`else
                    ok = 1;
`endif
                    if (ok) begin
                        m_pend = nd;
                        m_pv   = 1;
                    end
                end
                if (m_part[3] == 8'h31 && m_part[2] == 8'h31) m_pause = 1;
            end else if (m_err != 8'hFF) begin
                m_err = m_err + 8'd1;
            end
            m_part.delete();
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit v, input logic [7:0] b, input bit tk);
        rx_valid = v;
        rx_data  = b;
        tick     = tk;
        @(posedge clk);
        model_edge(v, b, tk);
        #1;
        rx_valid = 1'b0;
        tick     = 1'b0;
        check("dir_out", 32'(dir_out), 32'(m_dir));
        check("dir_valid", 32'(dir_valid), 32'(m_dv));
        check("pause_pulse", 32'(pause_pulse), 32'(m_pause));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    task automatic send5(input logic [39:0] pk, input int tick_at);
        for (int i = 0; i < 5; i++) step(1'b1, pk[39-8*i -: 8], (i == tick_at));
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        tick     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dir_out", 32'(dir_out), 32'h3);
        check("rst_dir_valid", 32'(dir_valid), 32'h0);
        check("rst_pause", 32'(pause_pulse), 32'h0);
        check("rst_err", 32'(err_cnt), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb[5];
        logic [7:0] s;
        int nb, gap, r;

        reset_n  = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick     = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Up packet then tick.
        send5(40'h21_42_35_31_36, -1);
        step(1'b0, 8'h00, 1'b1);
        check("up_dir", 32'(dir_out), 32'h0);
        check("up_dir_valid", 32'(dir_valid), 32'h1);
        step(1'b0, 8'h00, 1'b0);
        check("up_dir_valid_end", 32'(dir_valid), 32'h0);

        // Bad checksum: counted, nothing pending; then saturation.
        do_reset();
        send5(40'h21_42_37_31_00, -1);
        check("err_one", 32'(err_cnt), 32'h1);
        step(1'b0, 8'h00, 1'b1);
        check("err_no_pend", 32'(dir_out), 32'h3);
        for (int i = 0; i < 299; i++) send5(40'h21_42_37_31_00, -1);
        check("err_sat", 32'(err_cnt), 32'hFF);

        // Pause packet.
        do_reset();
        send5(40'h21_42_31_31_3A, -1);
        check("pause_hi", 32'(pause_pulse), 32'h1);
        step(1'b0, 8'h00, 1'b1);
        check("pause_lo", 32'(pause_pulse), 32'h0);
        check("pause_dir", 32'(dir_out), 32'h3);

        // Timeout mid-packet, then a full down packet.
        do_reset();
        step(1'b1, 8'h21, 1'b0);
        step(1'b1, 8'h42, 1'b0);
        step(1'b1, 8'h36, 1'b0);
        repeat (T) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h35, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("tmo_err", 32'(err_cnt), 32'h0);
        check("tmo_dir", 32'(dir_out), 32'h3);
        check("tmo_dv", 32'(dir_valid), 32'h0);
        send5(40'h21_42_36_31_35, -1);
        step(1'b0, 8'h00, 1'b1);
        check("tmo_down", 32'(dir_out), 32'h1);

        // Reset in the middle of a packet.
        step(1'b1, 8'h21, 1'b0);
        step(1'b1, 8'h42, 1'b0);
        do_reset();
        send5(40'h21_42_35_31_36, -1);
        step(1'b0, 8'h00, 1'b1);
        check("rst_mid_up", 32'(dir_out), 32'h0);

        // Last one wins; tick coincident with checksum.
        do_reset();
        send5(40'h21_42_35_31_36, -1);
        send5(40'h21_42_37_31_34, -1);
        step(1'b0, 8'h00, 1'b1);
        send5(40'h21_42_35_31_36, -1);
        send5(40'h21_42_37_31_34, 4);
        step(1'b0, 8'h00, 1'b1);
`ifndef SNAKE_NOREV_EN
        check("lastwin_left", 32'(dir_out), 32'h2);
`endif

        // Left while moving right.
        do_reset();
        send5(40'h21_42_37_31_34, -1);
        step(1'b0, 8'h00, 1'b1);
`ifdef SNAKE_NOREV_EN
        check("norev_drop", 32'(dir_out), 32'h3);
`else
        check("rev_accept", 32'(dir_out), 32'h2);
`endif

        // Randomized packet stream.
        do_reset();
        for (int p = 0; p < 400; p++) begin
            rb[0] = 8'h21;
            rb[1] = 8'h42;
            rb[2] = 8'($urandom_range(8'h31, 8'h38));
            rb[3] = 8'($urandom_range(8'h30, 8'h31));
            s = rb[0] + rb[1] + rb[2] + rb[3];
            rb[4] = 8'hFF - s;
            if ($urandom_range(0, 4) == 0) rb[4] = rb[4] + 8'($urandom_range(1, 255));
            if ($urandom_range(0, 9) == 0) rb[$urandom_range(0, 3)] = 8'($urandom);
            nb = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 4)) : 5;
            for (int i = 0; i < nb; i++) begin
                r = $urandom_range(0, 99);
                if (r < 3)      gap = T + $urandom_range(0, 2);
                else if (r < 6) gap = T - 1;
                else            gap = $urandom_range(0, 2);
                repeat (gap) step(1'b0, 8'($urandom), ($urandom_range(0, 9) == 0));
                step(1'b1, rb[i], ($urandom_range(0, 9) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/snake_cmd_decoder.md
SNAKE_CMD_DECODER -- requirements
Module: snake_cmd_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000000, inter-byte timeout in clk cycles (100 ms at 50 MHz).
REQ-002 Port clk, input, 1, system clock (50 MHz); all logic on its rising edge.
REQ-003 Port reset_n, input, 1, reset, asynchronous and active-low.
REQ-004 Port rx_valid, input, 1, one-cycle strobe from the UART receiver marking a new byte.
REQ-005 Port rx_data, input, 8, received byte; valid only while rx_valid is high.
REQ-006 Port tick, input, 1, one-cycle game-step strobe that consumes the pending direction.
REQ-007 Port dir_out, output, 2, committed snake direction: 00 up, 01 down, 10 left, 11 right.
REQ-008 Port dir_valid, output, 1, one-cycle pulse on the cycle after dir_out changes.
REQ-009 Port pause_pulse, output, 1, one-cycle pulse per accepted button-1 press.
REQ-010 Port err_cnt, output, 8, saturating count of checksum failures.

Function
REQ-011 The block SHALL parse 5-byte controller packets: '!'(0x21), 'B'(0x42), btn, state, chk.
REQ-012 Parser states SHALL be IDLE, GOT_BANG, GOT_B, GOT_BTN and GOT_STATE; each transition occurs only on rx_valid.
REQ-013 IDLE SHALL move to GOT_BANG on 0x21; any other byte leaves it in IDLE.
REQ-014 GOT_BANG SHALL move to GOT_B on 0x42.
REQ-015 GOT_B SHALL move to GOT_BTN on btn in '1'..'8' (0x31..0x38) and latch the byte.
REQ-016 GOT_BTN SHALL move to GOT_STATE on state '0' or '1' (0x30/0x31) and latch the byte.
REQ-017 In GOT_STATE, the next byte is the checksum, and the block SHALL then return to IDLE.
REQ-018 In any non-IDLE state, an unexpected byte SHALL go to GOT_BANG if it is 0x21, else to IDLE.
REQ-019 A packet SHALL be valid iff the 8-bit sum of all five bytes equals 0xFF.
REQ-020 An invalid checksum SHALL increment err_cnt, saturating at 0xFF.
REQ-021 For a valid packet with state '1': btn '5' → up, '6' → down, '7' → left, '8' → right, written into the pending register and setting pending_valid.
REQ-022 A valid press of btn '1' SHALL pulse pause_pulse on the cycle after the checksum byte.
REQ-023 Valid presses of buttons '2'..'4', and all valid releases (state '0'), SHALL be ignored without error.
REQ-024 A newer valid direction SHALL overwrite an unconsumed pending one; the last one wins.
REQ-025 On tick with pending_valid set, the block SHALL load dir_out from pending, clear pending_valid and pulse dir_valid one cycle later.
REQ-026 tick with no pending direction SHALL have no effect.
REQ-027 If tick and checksum completion fall in the same cycle, tick SHALL consume the old pending value and the new command SHALL become pending.
REQ-028 The timeout counter SHALL clear on every rx_valid and count while the parser is not in IDLE.
REQ-029 When the timeout counter reaches TIMEOUT_CYCLES-1, the parser SHALL return to IDLE without changing err_cnt.
REQ-030 Latency from the checksum strobe to the pending update or pause_pulse SHALL be exactly one cycle.

Reset
REQ-031 While reset_n is low, the block SHALL force: parser IDLE, dir_out 11 (right), dir_valid 0, pause_pulse 0, err_cnt 0, pending_valid 0, timeout counter 0.
REQ-032 Reset asserted mid-packet SHALL discard the partial packet; the first packet after release parses normally.

Configuration
REQ-033 Macro SNAKE_NOREV_EN: when defined, a valid direction that is opposite to dir_out or equal to dir_out SHALL be dropped, leaving pending unchanged.
REQ-034 When SNAKE_NOREV_EN is undefined, every valid direction SHALL be accepted into pending.

Structure
REQ-035 Package snake_cmd_pkg SHALL hold the dir_t enum (UP, DOWN, LEFT, RIGHT), the parser state enum and the byte constants (0x21, 0x42, button codes).
REQ-036 Sub-module bf_pkt_parser SHALL contain the FSM, checksum and timeout logic, outputting a one-cycle cmd strobe with btn and state.
REQ-037 The top level SHALL hold the pending register, the reversal filter, dir_out and err_cnt.

Verification
REQ-038 Reset, then bytes 21 42 35 31 36, then tick → dir_out=00 and a dir_valid pulse after the tick.
REQ-039 Bytes 21 42 37 31 00 → err_cnt=1 and pending unchanged; repeat 300 times → err_cnt=FF.
REQ-040 Bytes 21 42 31 31 3A → a single one-cycle pause_pulse and dir_out unchanged.
REQ-041 Bytes 21 42 36, then idle for TIMEOUT_CYCLES, then 31 35 → no command and err_cnt=0; a following full down packet (…36 31 35) is accepted.
REQ-042 Up packet, then left packet (21 42 37 31 34) before any tick; one tick → dir_out=10; tick coincident with the left checksum → up committed, left pending.
REQ-043 With SNAKE_NOREV_EN and dir_out=11, a left packet → dropped and the next tick has no effect; without the macro → dir_out=10 after the tick.
